// File: rtl/heap_pkg.sv
// Shared types for the parametrised priority heap: FSM states, tree-height
// helper and the {key, tag} entry struct macro.
`ifndef HEAP_PKG_SV
`define HEAP_PKG_SV

`define HEAP_ENTRY_T(kw, tw) struct packed { logic [(kw)-1:0] key; logic [(tw)-1:0] tag; }

package heap_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SIFT_UP   = 2'd1,
      SIFT_DOWN = 2'd2
   } heap_state_e;

   // Levels below the root of a full tree; also the width of a slot index.
   function automatic int heap_height(input int depth);
      return $clog2(depth);
   endfunction

   localparam int HEAP_TREE_H = heap_height(16);

endpackage

`endif

// File: rtl/heap_cmp.sv
// Combinational ordering test: better is high when key a should sit above key b.
module heap_cmp #(
   parameter int KEY_W    = 8,
   parameter int MIN_HEAP = 0
) (
   input  logic [KEY_W-1:0] a,
   input  logic [KEY_W-1:0] b,
   output logic             better
);

   // Strict comparison so equal keys never trigger a swap.
   always_comb begin
      if (MIN_HEAP != 0) better = (a < b);
      else               better = (a > b);
   end

endmodule

// File: rtl/param_prio_heap.sv
// Register-based binary heap priority queue with a multi-cycle sift FSM.
// Define HEAP_REPLACE_EN to enable the same-cycle replace-top path.
module param_prio_heap
   import heap_pkg::*;
#(
   parameter int KEY_W    = 8,
   parameter int TAG_W    = 4,
   parameter int DEPTH    = 16,
   parameter int MIN_HEAP = 0,
   parameter int CNT_W    = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [KEY_W-1:0] push_key,
   input  logic [TAG_W-1:0] push_tag,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [KEY_W-1:0] top_key,
   output logic [TAG_W-1:0] top_tag,
   output logic [CNT_W-1:0] count,
   output logic             heap_full,
   output logic             heap_empty,
   output logic             busy
);

   localparam int IDX_W = heap_height(DEPTH);
   localparam int WI_W  = IDX_W + 2;

   typedef `HEAP_ENTRY_T(KEY_W, TAG_W) entry_t;

   entry_t           mem [DEPTH];
   heap_state_e      state, state_nxt;
   logic [IDX_W-1:0] cur;

   logic             push_fire, pop_fire, do_replace;
   entry_t           push_entry;
   logic [CNT_W-1:0] count_m1;
   logic [IDX_W-1:0] tail_idx, push_idx, p_idx, l_idx, r_idx, b_idx, swap_idx;
   logic [WI_W-1:0]  cur_w, l_w, r_w, b_w, bl_w, count_w;
   logic             l_ok, r_ok, r_better, b_has_child;
   logic [KEY_W-1:0] node_a, node_b;
   logic             node_better, do_swap;

   // Handshake: push_valid/push_ready and pop_valid/pop_ready each transfer
   // on the rising edge where both are high; nothing is accepted unless IDLE.
   assign heap_full  = (count == CNT_W'(DEPTH));
   assign heap_empty = (count == '0);
   assign busy       = (state != IDLE);
   assign pop_valid  = (state == IDLE) && !heap_empty;
   assign top_key    = mem[0].key;
   assign top_tag    = mem[0].tag;

`ifdef HEAP_REPLACE_EN
   assign push_ready = (state == IDLE) && (!heap_full || pop_ready);
   assign do_replace = pop_fire && push_valid;
`else
   assign push_ready = (state == IDLE) && !heap_full && !(pop_valid && pop_ready);
   assign do_replace = 1'b0;
`endif

   assign push_fire  = push_valid && push_ready;
   assign pop_fire   = pop_valid && pop_ready;
   assign push_entry = '{key: push_key, tag: push_tag};

   assign count_m1 = count - CNT_W'(1);
   assign tail_idx = count_m1[IDX_W-1:0];
   assign push_idx = count[IDX_W-1:0];
   assign p_idx    = (cur - IDX_W'(1)) >> 1;

   // Child indices are computed wider than a slot index to avoid wrap-around.
   assign count_w = WI_W'(count);
   assign cur_w   = WI_W'(cur);
   assign l_w     = (cur_w << 1) + WI_W'(1);
   assign r_w     = (cur_w << 1) + WI_W'(2);
   assign l_ok    = (l_w < count_w);
   assign r_ok    = (r_w < count_w);
   assign l_idx   = l_ok ? l_w[IDX_W-1:0] : '0;
   assign r_idx   = r_ok ? r_w[IDX_W-1:0] : '0;
   assign b_idx   = (r_ok && r_better) ? r_idx : l_idx;
   assign b_w     = WI_W'(b_idx);
   assign bl_w    = (b_w << 1) + WI_W'(1);
   assign b_has_child = (bl_w < count_w);

   heap_cmp #(.KEY_W(KEY_W), .MIN_HEAP(MIN_HEAP)) u_cmp_child (
      .a      (mem[r_idx].key),
      .b      (mem[l_idx].key),
      .better (r_better)
   );

   assign node_a   = (state == SIFT_UP) ? mem[cur].key : mem[b_idx].key;
   assign node_b   = (state == SIFT_UP) ? mem[p_idx].key : mem[cur].key;
   assign swap_idx = (state == SIFT_UP) ? p_idx : b_idx;

   heap_cmp #(.KEY_W(KEY_W), .MIN_HEAP(MIN_HEAP)) u_cmp_node (
      .a      (node_a),
      .b      (node_b),
      .better (node_better)
   );

   always_comb begin
      do_swap = 1'b0;
      if (state == SIFT_UP)   do_swap = node_better;
      if (state == SIFT_DOWN) do_swap = l_ok && node_better;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (do_replace)     state_nxt = SIFT_DOWN;
            else if (pop_fire)  state_nxt = (count <= CNT_W'(2)) ? IDLE : SIFT_DOWN;
            else if (push_fire) state_nxt = heap_empty ? IDLE : SIFT_UP;
         end
         SIFT_UP:   state_nxt = (do_swap && p_idx != '0) ? SIFT_UP : IDLE;
         // Leave as soon as the moved entry lands on a leaf.
         SIFT_DOWN: state_nxt = (do_swap && b_has_child) ? SIFT_DOWN : IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         cur   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (do_replace) begin
                  mem[0] <= push_entry;
                  cur    <= '0;
               end else if (pop_fire) begin
                  // With one entry left the clear of the tail also empties the root.
                  mem[0]        <= mem[tail_idx];
                  mem[tail_idx] <= '0;
                  count         <= count_m1;
                  cur           <= '0;
               end else if (push_fire) begin
                  mem[push_idx] <= push_entry;
                  count         <= count + CNT_W'(1);
                  cur           <= push_idx;
               end
            end
            SIFT_UP, SIFT_DOWN: begin
               if (do_swap) begin
                  mem[cur]      <= mem[swap_idx];
                  mem[swap_idx] <= mem[cur];
                  cur           <= swap_idx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_param_prio_heap.sv
// Bench for param_prio_heap: a max heap and a min heap share one stimulus stream.
module tb_param_prio_heap;
   import heap_pkg::*;

   localparam int KEY_W    = 8;
   localparam int TAG_W    = 4;
   localparam int DEPTH    = 8;
   localparam int CNT_W    = $clog2(DEPTH+1);
   localparam int MAX_BUSY = heap_height(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             push_valid = 1'b0;
   logic             pop_ready = 1'b0;
   logic [KEY_W-1:0] push_key = '0;
   logic [TAG_W-1:0] push_tag = '0;

   logic             mx_push_ready, mx_pop_valid, mx_full, mx_empty, mx_busy;
   logic [KEY_W-1:0] mx_top_key;
   logic [TAG_W-1:0] mx_top_tag;
   logic [CNT_W-1:0] mx_count;
   logic             mn_push_ready, mn_pop_valid, mn_full, mn_empty, mn_busy;
   logic [KEY_W-1:0] mn_top_key;
   logic [TAG_W-1:0] mn_top_tag;
   logic [CNT_W-1:0] mn_count;

   int checks = 0;
   int errors = 0;

   logic [KEY_W-1:0] exp_q[$];
   logic [TAG_W-1:0] exp_tag_q[$];
   logic [KEY_W-1:0] mx_q[$];
   logic [KEY_W-1:0] mn_q[$];

   param_prio_heap #(.KEY_W(KEY_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .MIN_HEAP(0)) dut_max (
      .clk(clk), .reset(reset), .push_valid(push_valid), .push_ready(mx_push_ready),
      .push_key(push_key), .push_tag(push_tag), .pop_valid(mx_pop_valid), .pop_ready(pop_ready),
      .top_key(mx_top_key), .top_tag(mx_top_tag), .count(mx_count), .heap_full(mx_full),
      .heap_empty(mx_empty), .busy(mx_busy)
   );

   param_prio_heap #(.KEY_W(KEY_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .MIN_HEAP(1)) dut_min (
      .clk(clk), .reset(reset), .push_valid(push_valid), .push_ready(mn_push_ready),
      .push_key(push_key), .push_tag(push_tag), .pop_valid(mn_pop_valid), .pop_ready(pop_ready),
      .top_key(mn_top_key), .top_tag(mn_top_tag), .count(mn_count), .heap_full(mn_full),
      .heap_empty(mn_empty), .busy(mn_busy)
   );

   // Clock and reset
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic apply_reset;
      reset = 1'b1;
      push_valid = 1'b0;
      pop_ready = 1'b0;
      mx_q.delete();
      mn_q.delete();
      exp_q.delete();
      exp_tag_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Driver tasks: entered and left 1 time unit after a rising edge.
   task automatic wait_idle;
      int n = 0;
      while ((mx_busy || mn_busy) && n <= MAX_BUSY) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n > MAX_BUSY) begin
         errors++;
         $display("FAIL busy_bound: got %0d busy cycles expected <= %0d", n, MAX_BUSY);
      end
   endtask

   task automatic do_push(input logic [KEY_W-1:0] key, input logic [TAG_W-1:0] tag);
      push_key = key;
      push_tag = tag;
      push_valid = 1'b1;
      #1;
      checks++;
      if (mx_push_ready !== 1'b1) begin
         errors++;
         $display("FAIL push_ready: got %b expected 1 (key %0d)", mx_push_ready, key);
      end
      @(posedge clk);
      #1 push_valid = 1'b0;
      mx_q.push_back(key);
      mn_q.push_back(key);
      wait_idle();
   endtask

   task automatic do_pop(output logic [KEY_W-1:0] mxk, output logic [TAG_W-1:0] mxt,
                         output logic [KEY_W-1:0] mnk, output logic [TAG_W-1:0] mnt);
      pop_ready = 1'b1;
      #1;
      checks++;
      if (mx_pop_valid !== 1'b1) begin
         errors++;
         $display("FAIL pop_valid: got %b expected 1", mx_pop_valid);
      end
      mxk = mx_top_key;
      mxt = mx_top_tag;
      mnk = mn_top_key;
      mnt = mn_top_tag;
      @(posedge clk);
      #1 pop_ready = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset;
      apply_reset();
      checks += 8;
      if (mx_count !== '0)        begin errors++; $display("FAIL rst_count: got %0d expected 0", mx_count); end
      if (mx_push_ready !== 1'b1) begin errors++; $display("FAIL rst_push_ready: got %b expected 1", mx_push_ready); end
      if (mx_pop_valid !== 1'b0)  begin errors++; $display("FAIL rst_pop_valid: got %b expected 0", mx_pop_valid); end
      if (mx_top_key !== '0)      begin errors++; $display("FAIL rst_top_key: got %0d expected 0", mx_top_key); end
      if (mx_top_tag !== '0)      begin errors++; $display("FAIL rst_top_tag: got %0d expected 0", mx_top_tag); end
      if (mx_empty !== 1'b1)      begin errors++; $display("FAIL rst_empty: got %b expected 1", mx_empty); end
      if (mx_full !== 1'b0)       begin errors++; $display("FAIL rst_full: got %b expected 0", mx_full); end
      if (mx_busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b expected 0", mx_busy); end
   endtask

   task automatic test_sort;
      logic [KEY_W-1:0] keys [6] = '{10, 20, 5, 7, 25, 3};
      logic [KEY_W-1:0] mxk, mnk;
      logic [TAG_W-1:0] mxt, mnt;
      apply_reset();
      for (int i = 0; i < 6; i++) do_push(keys[i], TAG_W'(i));
      checks += 2;
      if (mx_top_key !== 8'd25) begin errors++; $display("FAIL sort_top: got %0d expected 25", mx_top_key); end
      if (mx_count !== 4'd6)    begin errors++; $display("FAIL sort_count: got %0d expected 6", mx_count); end
      exp_q = '{25, 20, 10, 7, 5, 3};
      exp_tag_q = '{4, 1, 0, 3, 2, 5};
      while (exp_q.size() > 0) begin
         logic [KEY_W-1:0] ek;
         logic [TAG_W-1:0] et;
         ek = exp_q.pop_front();
         et = exp_tag_q.pop_front();
         do_pop(mxk, mxt, mnk, mnt);
         checks += 2;
         if (mxk !== ek) begin errors++; $display("FAIL sort_pop_key: got %0d expected %0d", mxk, ek); end
         if (mxt !== et) begin errors++; $display("FAIL sort_pop_tag: got %0d expected %0d", mxt, et); end
      end
      checks += 2;
      if (mx_empty !== 1'b1) begin errors++; $display("FAIL sort_empty: got %b expected 1", mx_empty); end
      if (mx_top_key !== '0) begin errors++; $display("FAIL sort_empty_top: got %0d expected 0", mx_top_key); end
   endtask

   task automatic test_full;
      logic [KEY_W-1:0] keys [8] = '{40, 11, 63, 2, 90, 17, 55, 30};
      logic [KEY_W-1:0] mxk, mnk;
      logic [TAG_W-1:0] mxt, mnt;
      apply_reset();
      for (int i = 0; i < 8; i++) do_push(keys[i], TAG_W'(i));
      checks += 2;
      if (mx_full !== 1'b1)       begin errors++; $display("FAIL full_flag: got %b expected 1", mx_full); end
      if (mx_push_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", mx_push_ready); end
      push_key = 8'd99;
      push_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (mx_push_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready: got %b expected 0", mx_push_ready); end
         @(posedge clk);
         #1;
      end
      push_valid = 1'b0;
      checks += 2;
      if (mx_count !== 4'd8)    begin errors++; $display("FAIL full_hold_count: got %0d expected 8", mx_count); end
      if (mx_top_key !== 8'd90) begin errors++; $display("FAIL full_hold_top: got %0d expected 90", mx_top_key); end
      do_pop(mxk, mxt, mnk, mnt);
      checks += 3;
      if (mxk !== 8'd90)          begin errors++; $display("FAIL full_pop: got %0d expected 90", mxk); end
      if (mx_push_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b expected 1", mx_push_ready); end
      if (mx_count !== 4'd7)      begin errors++; $display("FAIL full_count_after: got %0d expected 7", mx_count); end
   endtask

   task automatic test_min_tags;
      logic [KEY_W-1:0] mxk, mnk;
      logic [TAG_W-1:0] mxt, mnt;
      apply_reset();
      do_push(8'd9, 4'd0);
      do_push(8'd2, 4'd1);
      do_push(8'd6, 4'd2);
      do_push(8'd2, 4'd3);
      exp_q = '{2, 2, 6, 9};
      exp_tag_q = '{1, 3, 2, 0};
      while (exp_q.size() > 0) begin
         logic [KEY_W-1:0] ek;
         logic [TAG_W-1:0] et;
         ek = exp_q.pop_front();
         et = exp_tag_q.pop_front();
         do_pop(mxk, mxt, mnk, mnt);
         checks += 2;
         if (mnk !== ek) begin errors++; $display("FAIL min_key: got %0d expected %0d", mnk, ek); end
         if (mnt !== et) begin errors++; $display("FAIL min_tag: got %0d expected %0d", mnt, et); end
      end
   endtask

   task automatic test_same_cycle;
      logic [KEY_W-1:0] mxk, mnk;
      logic [TAG_W-1:0] mxt, mnt;
      apply_reset();
`ifdef HEAP_REPLACE_EN
      begin
         logic [KEY_W-1:0] keys [8] = '{30, 10, 25, 5, 8, 22, 1, 3};
         for (int i = 0; i < 8; i++) do_push(keys[i], TAG_W'(i));
         exp_q = '{25, 22, 15, 10, 8, 5, 3, 1};
      end
`else
      do_push(8'd30, 4'd0);
      do_push(8'd12, 4'd1);
      do_push(8'd20, 4'd2);
      exp_q = '{20, 12};
`endif
      push_key = 8'd15;
      push_tag = 4'd9;
      push_valid = 1'b1;
      pop_ready = 1'b1;
      #1;
      checks += 2;
`ifdef HEAP_REPLACE_EN
      if (mx_push_ready !== 1'b1) begin errors++; $display("FAIL replace_ready: got %b expected 1", mx_push_ready); end
`else
      if (mx_push_ready !== 1'b0) begin errors++; $display("FAIL both_ready: got %b expected 0", mx_push_ready); end
`endif
      if (mx_top_key !== 8'd30) begin errors++; $display("FAIL both_popped: got %0d expected 30", mx_top_key); end
      @(posedge clk);
      #1;
      push_valid = 1'b0;
      pop_ready = 1'b0;
      wait_idle();
      checks++;
      if (mx_count !== CNT_W'(exp_q.size())) begin
         errors++;
         $display("FAIL both_count: got %0d expected %0d", mx_count, exp_q.size());
      end
      while (exp_q.size() > 0) begin
         logic [KEY_W-1:0] ek;
         ek = exp_q.pop_front();
         do_pop(mxk, mxt, mnk, mnt);
         checks++;
         if (mxk !== ek) begin errors++; $display("FAIL both_drain: got %0d expected %0d", mxk, ek); end
      end
   endtask

   task automatic test_reset_mid_sift;
      apply_reset();
      for (int i = 1; i <= 8; i++) do_push(KEY_W'(i), TAG_W'(i));
      pop_ready = 1'b1;
      @(posedge clk);
      #1 pop_ready = 1'b0;
      checks++;
      if (mx_busy !== 1'b1) begin errors++; $display("FAIL mid_sift_busy: got %b expected 1", mx_busy); end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      mx_q.delete();
      mn_q.delete();
      checks += 4;
      if (mx_count !== '0)        begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", mx_count); end
      if (mx_busy !== 1'b0)       begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", mx_busy); end
      if (mx_top_key !== '0)      begin errors++; $display("FAIL mid_rst_top: got %0d expected 0", mx_top_key); end
      if (mx_push_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", mx_push_ready); end
   endtask

   // Scoreboard: unsorted reference multisets, best entry chosen on each pop.
   task automatic test_random;
      logic [KEY_W-1:0] mxk, mnk;
      logic [TAG_W-1:0] mxt, mnt;
      apply_reset();
      for (int op = 0; op < 1000; op++) begin
         if (mx_q.size() == 0 || (mx_q.size() < DEPTH && $urandom_range(0, 1) == 1)) begin
            do_push(KEY_W'($urandom_range(0, 31)), TAG_W'($urandom_range(0, 15)));
         end else begin
            int bi = 0;
            int si = 0;
            for (int i = 1; i < mx_q.size(); i++) if (mx_q[i] > mx_q[bi]) bi = i;
            for (int i = 1; i < mn_q.size(); i++) if (mn_q[i] < mn_q[si]) si = i;
            do_pop(mxk, mxt, mnk, mnt);
            checks += 2;
            if (mxk !== mx_q[bi]) begin errors++; $display("FAIL rand_max_pop: got %0d expected %0d", mxk, mx_q[bi]); end
            if (mnk !== mn_q[si]) begin errors++; $display("FAIL rand_min_pop: got %0d expected %0d", mnk, mn_q[si]); end
            mx_q.delete(bi);
            mn_q.delete(si);
         end
         checks++;
         if (mx_count !== CNT_W'(mx_q.size())) begin
            errors++;
            $display("FAIL rand_count: got %0d expected %0d", mx_count, mx_q.size());
         end
      end
   endtask

   // Report
   initial begin
      test_reset();
      test_sort();
      test_full();
      test_min_tags();
      test_same_cycle();
      test_reset_mid_sift();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
